// File: rtl/mapper_mem_req.sv
// mapper_mem_req: registered memory-request stage behind every mapper.
// Each rising edge of acc_valid starts exactly one CPU memory cycle. When the
// mapper selects memory, the cycle becomes one arbiter request, and the Z80 is
// held in WAIT until mem_ack arrives. Unmapped cycles read as 0xFF and never
// reach memory.
// Optional feature: define MAPPER_REQ_TIMEOUT_EN to add a request watchdog.
// The watchdog drops a stalled request after TIMEOUT_CYCLES cycles in REQ and
// sets the sticky err_timeout flag. Without the macro, err_timeout is tied to 0.

module mapper_mem_req #(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  acc_valid,
    input  logic                  map_ram_cs,
    input  logic [ADDR_WIDTH-1:0] map_addr,
    input  logic                  map_rnw,
    input  logic [7:0]            map_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_din,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_dout,
    output logic                  cpu_wait_n,
    output logic [7:0]            cpu_rdata,
    output logic                  err_timeout
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  acc_prev_q;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic [7:0]            cpu_rdata_q, cpu_rdata_d;
    logic                  start;

`ifdef MAPPER_REQ_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                err_q, err_d;
`endif

    // A new CPU cycle is only the rising edge; a held level never re-triggers.
    assign start = acc_valid & ~acc_prev_q;

    // Next-state decode for the request FSM and the latched request fields.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_din_d   = mem_din_q;
        cpu_rdata_d = cpu_rdata_q;
`ifdef MAPPER_REQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (map_ram_cs) begin
                        mem_addr_d = map_addr;
                        mem_we_d   = ~map_rnw;
                        mem_din_d  = map_data;
                        mem_req_d  = 1'b1;
                        state_d    = StReq;
`ifdef MAPPER_REQ_TIMEOUT_EN
                        tmo_cnt_d  = '0;
`endif
                    end else begin
                        cpu_rdata_d = 8'hFF;
                        state_d     = StDone;
                    end
                end
            end
            StReq: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_dout;
                    end
                    // A cycle the CPU already abandoned goes straight back to idle.
                    state_d = acc_valid ? StDone : StIdle;
                end
`ifdef MAPPER_REQ_TIMEOUT_EN
                else if (tmo_cnt_q == CntLast) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_rdata_d = 8'hFF;
                    end
                    err_d   = 1'b1;
                    state_d = acc_valid ? StDone : StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CntWidth'(1);
                end
`endif
            end
            StDone: begin
                if (!acc_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and latched request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            acc_prev_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_din_q   <= 8'h00;
            cpu_rdata_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            acc_prev_q  <= acc_valid;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_din_q   <= mem_din_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

`ifdef MAPPER_REQ_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // WAIT asserts in the start cycle itself so the CPU never samples stale data.
    always_comb begin
        cpu_wait_n = 1'b1;
        if (reset_n) begin
            if ((state_q == StReq) || ((state_q == StIdle) && start && map_ram_cs)) begin
                cpu_wait_n = 1'b0;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_din   = mem_din_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_mapper_mem_req.sv
// Directed testbench for mapper_mem_req with hand-computed expected values.
// The timeout scenario is compiled only when MAPPER_REQ_TIMEOUT_EN is defined.

module tb_mapper_mem_req;

`ifdef MAPPER_REQ_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 8;
`else
    localparam int unsigned TimeoutCycles = 1024;
`endif
    localparam int unsigned AddrWidth = 27;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 acc_valid;
    logic                 map_ram_cs;
    logic [AddrWidth-1:0] map_addr;
    logic                 map_rnw;
    logic [7:0]           map_data;
    logic                 mem_req;
    logic [AddrWidth-1:0] mem_addr;
    logic                 mem_we;
    logic [7:0]           mem_din;
    logic                 mem_ack;
    logic [7:0]           mem_dout;
    logic                 cpu_wait_n;
    logic [7:0]           cpu_rdata;
    logic                 err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    mapper_mem_req #(
        .ADDR_WIDTH    (AddrWidth),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .acc_valid  (acc_valid),
        .map_ram_cs (map_ram_cs),
        .map_addr   (map_addr),
        .map_rnw    (map_rnw),
        .map_data   (map_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_ack    (mem_ack),
        .mem_dout   (mem_dout),
        .cpu_wait_n (cpu_wait_n),
        .cpu_rdata  (cpu_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int req_rises;
    logic req_prev;

    initial begin
        reset_n    = 1'b0;
        acc_valid  = 1'b0;
        map_ram_cs = 1'b0;
        map_addr   = '0;
        map_rnw    = 1'b1;
        map_data   = 8'h00;
        mem_ack    = 1'b0;
        mem_dout   = 8'h00;

        // Reset state
        step();
        check_eq("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        step();
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_din", 32'(mem_din), 32'd0);
        check_eq("rst_rdata", 32'(cpu_rdata), 32'hFF);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        reset_n = 1'b1;
        step();

        // Read hit, ack in the third request cycle
        acc_valid  = 1'b1;
        map_ram_cs = 1'b1;
        map_addr   = 27'h0004000;
        map_rnw    = 1'b1;
        #1;
        check_eq("rd_wait_start", 32'(cpu_wait_n), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rd_req_hi", 32'(mem_req), 32'd1);
            check_eq("rd_wait_lo", 32'(cpu_wait_n), 32'd0);
        end
        check_eq("rd_we", 32'(mem_we), 32'd0);
        check_eq("rd_addr", 32'(mem_addr), 32'h0004000);
        mem_ack  = 1'b1;
        mem_dout = 8'h5A;
        #1;
        check_eq("rd_wait_ack", 32'(cpu_wait_n), 32'd0);
        step();
        mem_ack = 1'b0;
        check_eq("rd_req_drop", 32'(mem_req), 32'd0);
        check_eq("rd_rdata", 32'(cpu_rdata), 32'h5A);
        check_eq("rd_wait_rel", 32'(cpu_wait_n), 32'd1);
        acc_valid = 1'b0;
        step();

        // Write to the top address; mapper inputs change after the latch
        acc_valid = 1'b1;
        map_addr  = 27'h7FFFFFF;
        map_data  = 8'hC3;
        map_rnw   = 1'b0;
        step();
        map_addr = '0;
        map_data = 8'h00;
        map_rnw  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_eq("wr_req", 32'(mem_req), 32'd1);
            check_eq("wr_we", 32'(mem_we), 32'd1);
            check_eq("wr_din", 32'(mem_din), 32'hC3);
            check_eq("wr_addr", 32'(mem_addr), 32'h7FFFFFF);
            if (i == 0) step();
        end
        mem_ack  = 1'b1;
        mem_dout = 8'hEE;
        step();
        mem_ack = 1'b0;
        check_eq("wr_req_drop", 32'(mem_req), 32'd0);
        check_eq("wr_rdata_keep", 32'(cpu_rdata), 32'h5A);
        check_eq("wr_wait_rel", 32'(cpu_wait_n), 32'd1);
        acc_valid = 1'b0;
        step();

        // Unmapped read
        acc_valid  = 1'b1;
        map_ram_cs = 1'b0;
        map_rnw    = 1'b1;
        #1;
        check_eq("um_wait_start", 32'(cpu_wait_n), 32'd1);
        step();
        check_eq("um_req", 32'(mem_req), 32'd0);
        check_eq("um_wait", 32'(cpu_wait_n), 32'd1);
        check_eq("um_rdata", 32'(cpu_rdata), 32'hFF);
        step();
        check_eq("um_req2", 32'(mem_req), 32'd0);
        acc_valid = 1'b0;
        step();

        // Long acc_valid: one request only, ack after two request cycles
        acc_valid  = 1'b1;
        map_ram_cs = 1'b1;
        map_addr   = 27'h0123456;
        mem_dout   = 8'h3C;
        req_rises  = 0;
        req_prev   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = (i == 2);
            step();
            if (mem_req && !req_prev) req_rises++;
            req_prev = mem_req;
        end
        mem_ack = 1'b0;
        check_eq("long_one_req", 32'(req_rises), 32'd1);
        check_eq("long_rdata", 32'(cpu_rdata), 32'h3C);
        check_eq("long_wait", 32'(cpu_wait_n), 32'd1);
        acc_valid = 1'b0;
        step();
        acc_valid = 1'b1;
        #1;
        check_eq("long_second_wait", 32'(cpu_wait_n), 32'd0);
        step();
        check_eq("long_second_req", 32'(mem_req), 32'd1);
        mem_ack  = 1'b1;
        mem_dout = 8'h96;
        step();
        mem_ack = 1'b0;
        check_eq("long_second_rdata", 32'(cpu_rdata), 32'h96);
        acc_valid = 1'b0;
        step();

        // acc_valid falls during REQ, then rises as the FSM returns to idle
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
        step();
        mem_ack  = 1'b1;
        mem_dout = 8'hA7;
        step();
        mem_ack = 1'b0;
        check_eq("fall_rdata", 32'(cpu_rdata), 32'hA7);
        check_eq("fall_req", 32'(mem_req), 32'd0);
        acc_valid = 1'b1;
        #1;
        check_eq("fall_restart_wait", 32'(cpu_wait_n), 32'd0);
        step();
        check_eq("fall_restart_req", 32'(mem_req), 32'd1);
        mem_ack  = 1'b1;
        mem_dout = 8'h42;
        step();
        mem_ack   = 1'b0;
        acc_valid = 1'b0;
        step();

`ifdef MAPPER_REQ_TIMEOUT_EN
        // Read with no ack: watchdog ends the request after eight cycles
        acc_valid = 1'b1;
        map_rnw   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("to_req_hi", 32'(mem_req), 32'd1);
        end
        step();
        check_eq("to_req_drop", 32'(mem_req), 32'd0);
        check_eq("to_rdata", 32'(cpu_rdata), 32'hFF);
        check_eq("to_err", 32'(err_timeout), 32'd1);
        check_eq("to_wait", 32'(cpu_wait_n), 32'd1);
        acc_valid = 1'b0;
        step();
        step();
        check_eq("to_err_sticky", 32'(err_timeout), 32'd1);
`else
        check_eq("err_tied_low", 32'(err_timeout), 32'd0);
`endif

        // Reset asserted in the second REQ cycle, late ack afterwards
        acc_valid = 1'b1;
        map_rnw   = 1'b1;
        step();
        step();
        check_eq("mr_req_before", 32'(mem_req), 32'd1);
        reset_n   = 1'b0;
        acc_valid = 1'b0;
        #1;
        check_eq("mr_wait_in_rst", 32'(cpu_wait_n), 32'd1);
        step();
        check_eq("mr_req_drop", 32'(mem_req), 32'd0);
        reset_n  = 1'b1;
        mem_ack  = 1'b1;
        mem_dout = 8'h11;
        step();
        mem_ack = 1'b0;
        check_eq("mr_req_late_ack", 32'(mem_req), 32'd0);
        check_eq("mr_wait", 32'(cpu_wait_n), 32'd1);
        check_eq("mr_rdata", 32'(cpu_rdata), 32'hFF);
        check_eq("mr_err_clr", 32'(err_timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
